// File: rtl/sseg_pkg.sv
// Shared types and helpers for the eight-digit seven-segment scan controller.
package sseg_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam logic [7:0] AN_ALL_OFF = 8'hFF;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // One complete display configuration (used for both the pending and active sets)
   typedef struct packed {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic        lzb;
   } disp_cfg_t;

   // Pick nibble i (bits 4i+3..4i) out of a 32-bit value
   function automatic logic [3:0] nib_sel(input logic [31:0] v, input logic [2:0] i);
      return v[{i, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/sseg_lzb_mask.sv
// Leading-zero blanking mask: bit i is 1 when digit i survives blanking.
// Digit 0 always survives so an all-zero value still shows a single "0".
module sseg_lzb_mask
   import sseg_pkg::*;
(
   input  logic [31:0]           value,
   input  logic                  lzb,
   output logic [NUM_DIGITS-1:0] vis
);

   logic nz;

   // Scan from the most significant digit down, remembering whether any nonzero nibble was seen
   always_comb begin
      nz  = 1'b0;
      vis = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz     = nz | (nib_sel(value, 3'(i)) != 4'h0);
         vis[i] = !lzb || nz || (i == 0);
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for an eight-digit common-anode display.
// Each digit slot starts with a dead-time blank window, then drives the anode.
// New content is committed only at the frame boundary (last DRIVE cycle of digit 7).
// All outputs are registered from the next-state values so they line up with the
// state the FSM is entering.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int REFRESH_CYCLES = 100000,
   parameter int DEAD_CYCLES    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  digit_en,
   input  logic        lzb,
   input  logic        load,
   output logic [3:0]  hex,
   output logic [7:0]  AN,
   output logic        DP,
   output logic        frame_done
);

   localparam int            CW        = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   scan_state_t     state, nxt_state;
   logic [CW-1:0]   cnt, nxt_cnt;
   logic [2:0]      idx, nxt_idx;
   disp_cfg_t       pend, act, nxt_act, cfg_in;
   logic [7:0]      vis_mask;
   logic            commit;
   logic [3:0]      nxt_hex;
   logic [7:0]      nxt_an;
   logic            nxt_dp, nxt_frame;

   assign cfg_in = '{value: value, dp: dp_mask, en: digit_en, lzb: lzb};

   // Visibility is evaluated on the configuration that will be active next cycle
   sseg_lzb_mask u_lzb (
      .value (nxt_act.value),
      .lzb   (nxt_act.lzb),
      .vis   (vis_mask)
   );

   // Scan FSM next-state: dead window, then drive until the slot ends
   always_comb begin
      nxt_state = state;
      case (state)
         BLANK:   if (cnt == DEAD_LAST) nxt_state = DRIVE;
         DRIVE:   if (cnt == CNT_LAST)  nxt_state = BLANK;
         default: nxt_state = BLANK;
      endcase
   end

   // Slot counter, digit index, commit and registered-output next values
   always_comb begin
      nxt_cnt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      nxt_idx = (cnt == CNT_LAST) ? idx + 3'd1 : idx;
      commit  = (state == DRIVE) && (cnt == CNT_LAST) && (idx == 3'd7);

      // A load on the commit cycle goes straight to the active set
      nxt_act = act;
      if (commit) nxt_act = load ? cfg_in : pend;

      nxt_frame = (nxt_state == DRIVE) && (nxt_cnt == CNT_LAST) && (nxt_idx == 3'd7);

      // hex changes only at the start of the dead window so the decoder settles first
      nxt_hex = hex;
      if (nxt_state == BLANK && nxt_cnt == '0) nxt_hex = nib_sel(nxt_act.value, nxt_idx);

      nxt_an = AN_ALL_OFF;
      nxt_dp = 1'b1;
      if (nxt_state == DRIVE && vis_mask[nxt_idx] && nxt_act.en[nxt_idx]) begin
         nxt_an = ~(8'b1 << nxt_idx);
         nxt_dp = ~nxt_act.dp[nxt_idx];
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= BLANK;
      else       state <= nxt_state;
   end

   // Counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         hex        <= 4'h0;
         AN         <= AN_ALL_OFF;
         DP         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt        <= nxt_cnt;
         idx        <= nxt_idx;
         hex        <= nxt_hex;
         AN         <= nxt_an;
         DP         <= nxt_dp;
         frame_done <= nxt_frame;
      end
   end

   // Pending set follows every load; active set changes only at commit
   always_ff @(posedge clk) begin
      if (reset) begin
         pend <= '0;
         act  <= '0;
      end else begin
         if (load) pend <= cfg_in;
         act <= nxt_act;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with an 8-cycle slot and 2-cycle dead window.
module tb_sseg_scan_ctrl;

   localparam int R = 8;
   localparam int D = 2;

   logic        clk = 1'b0;
   logic        reset, lzb, load;
   logic [31:0] value;
   logic [7:0]  dp_mask, digit_en;
   logic [3:0]  hex;
   logic [7:0]  AN;
   logic        DP, frame_done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sseg_scan_ctrl #(.REFRESH_CYCLES(R), .DEAD_CYCLES(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .dp_mask    (dp_mask),
      .digit_en   (digit_en),
      .lzb        (lzb),
      .load       (load),
      .hex        (hex),
      .AN         (AN),
      .DP         (DP),
      .frame_done (frame_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One-cycle load strobe
   task automatic ld(input logic [31:0] v, input logic [7:0] dpm, input logic [7:0] en, input logic lz);
      value    = v;
      dp_mask  = dpm;
      digit_en = en;
      lzb      = lz;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   // Called at cycle 0 of a frame; checks all 64 cycles and ends at cycle 0 of the next frame.
   // drive: hand-computed set of digits that should light their anode.
   task automatic check_frame(input string tag, input logic [31:0] v,
                              input logic [7:0] drive, input logic [7:0] dpm);
      logic [7:0] e_an;
      logic       e_dp, e_fd;
      logic [3:0] e_hex;
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < R; c++) begin
            if (c < D || !drive[i]) begin
               e_an = 8'hFF;
               e_dp = 1'b1;
            end else begin
               e_an = ~(8'b1 << i);
               e_dp = ~dpm[i];
            end
            e_hex = v[4*i +: 4];
            e_fd  = (i == 7) && (c == R - 1);
            chk($sformatf("%s AN d%0d c%0d", tag, i, c), AN, e_an);
            chk($sformatf("%s DP d%0d c%0d", tag, i, c), DP, e_dp);
            chk($sformatf("%s hex d%0d c%0d", tag, i, c), hex, e_hex);
            chk($sformatf("%s frame_done d%0d c%0d", tag, i, c), frame_done, e_fd);
            tick();
         end
      end
   endtask

   // Run to the commit cycle, then step into cycle 0 of the next frame
   task automatic wait_frame(input string tag);
      int n = 0;
      while (frame_done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, " frame_done seen"}, frame_done, 1'b1);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] e_an;
      reset    = 1'b1;
      value    = '0;
      dp_mask  = '0;
      digit_en = '0;
      lzb      = 1'b0;
      load     = 1'b0;
      tick();
      tick();
      chk("reset AN", AN, 8'hFF);
      chk("reset DP", DP, 1'b1);
      chk("reset hex", hex, 4'h0);
      chk("reset frame_done", frame_done, 1'b0);
      reset = 1'b0;

      // Idle: dark display, frame_done every 64 cycles
      check_frame("idle0", 32'h0, 8'h00, 8'h00);
      check_frame("idle1", 32'h0, 8'h00, 8'h00);

      // Plain hex scan
      ld(32'h89AB_CDEF, 8'h00, 8'hFF, 1'b0);
      wait_frame("hex");
      check_frame("hex", 32'h89AB_CDEF, 8'hFF, 8'h00);

      // Leading-zero blanking
      ld(32'h0000_0120, 8'h00, 8'hFF, 1'b1);
      wait_frame("lzb120");
      check_frame("lzb120", 32'h0000_0120, 8'h07, 8'h00);
      ld(32'h0000_0000, 8'h00, 8'hFF, 1'b1);
      wait_frame("lzb0");
      check_frame("lzb0", 32'h0, 8'h01, 8'h00);

      // Decimal point on a disabled digit, then enabled
      ld(32'h0123_4567, 8'h04, 8'hFB, 1'b0);
      wait_frame("dpoff");
      check_frame("dpoff", 32'h0123_4567, 8'hFB, 8'h04);
      ld(32'h0123_4567, 8'h04, 8'hFF, 1'b0);
      wait_frame("dpon");
      check_frame("dpon", 32'h0123_4567, 8'hFF, 8'h04);

      // Loads A and B mid-frame never show; C on the commit cycle shows next frame
      fork
         check_frame("noab", 32'h0123_4567, 8'hFF, 8'h04);
         begin
            tick();
            ld(32'hAAAA_AAAA, 8'h04, 8'hFF, 1'b0);
            repeat (20) tick();
            ld(32'hBBBB_BBBB, 8'h04, 8'hFF, 1'b0);
            repeat (40) tick();
            ld(32'hC0DE_1234, 8'h00, 8'hFF, 1'b0);
         end
      join
      check_frame("bypassC", 32'hC0DE_1234, 8'hFF, 8'h00);
      check_frame("recommitC", 32'hC0DE_1234, 8'hFF, 8'h00);

      // Reset during digit-5 DRIVE discards the pending load
      ld(32'h5555_5555, 8'h00, 8'hFF, 1'b0);
      repeat (43) tick();
      e_an = 8'hDF;
      chk("pre-reset AN d5", AN, e_an);
      chk("pre-reset hex d5", hex, 4'hD);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset AN", AN, 8'hFF);
      chk("midreset DP", DP, 1'b1);
      chk("midreset hex", hex, 4'h0);
      chk("midreset frame_done", frame_done, 1'b0);
      check_frame("dark0", 32'h0, 8'h00, 8'h00);
      check_frame("dark1", 32'h0, 8'h00, 8'h00);

      // Recovery after reset, with blanking and digit-0 decimal point
      ld(32'h0000_00A7, 8'h01, 8'hFF, 1'b1);
      wait_frame("recover");
      check_frame("recover", 32'h0000_00A7, 8'h03, 8'h01);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
